inert_spi_resp: RTL and testbench

INERT_SPI_RESP -- requirements
Module: inert_spi_resp

---
 rtl/inert_spi_resp.sv | 274 +++++++++++++++++++++++++++
 tb/tb_inert_spi_resp.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/inert_spi_resp.sv
// SPI-mode-3 register responder for an inertial sensor front end.
// Serves config registers, WHO_AM_I and a shadow snapshot of the five
// sensor words, and raises INT when a new snapshot is taken.
module inert_spi_resp #(
  parameter logic [7:0] WHO_AM_I = 8'h6A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        INT,
  input  logic [15:0] ptch_rt,
  input  logic [15:0] roll_rt,
  input  logic [15:0] yaw_rt,
  input  logic [15:0] ax,
  input  logic [15:0] ay,
  input  logic        smpl_vld,
  output logic [7:0]  int_cfg,
  output logic [7:0]  accl_cfg,
  output logic [7:0]  gyro_cfg,
  output logic [7:0]  rnd_cfg
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  logic [1:0] ss_sync_q, sclk_sync_q, mosi_sync_q;
  logic       ss_prev_q, sclk_prev_q;
  logic       ss_s, sclk_s, mosi_s;
  logic       ss_fall, ss_rise, sclk_rise, sclk_fall, rise_ok;

  state_t      state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic        miso_q, miso_d;
  logic        wr_go_q, wr_go_d;

  logic [7:0]  int_cfg_q, int_cfg_d, accl_cfg_q, accl_cfg_d;
  logic [7:0]  gyro_cfg_q, gyro_cfg_d, rnd_cfg_q, rnd_cfg_d;

  logic [15:0] snap_ptch_q, snap_roll_q, snap_yaw_q, snap_ax_q, snap_ay_q;
  logic [15:0] snap_ptch_d, snap_roll_d, snap_yaw_d, snap_ax_d, snap_ay_d;
  logic [15:0] hold_ptch_q, hold_roll_q, hold_yaw_q, hold_ax_q, hold_ay_q;
  logic [15:0] hold_ptch_d, hold_roll_d, hold_yaw_d, hold_ax_d, hold_ay_d;
  logic        pending_q, pending_d;
  logic        load_q, load_d;
  logic        int_q, int_d;
  logic        int_clr;

  logic [6:0]  rd_addr;
  logic [7:0]  rd_byte;

  // Synchronizers and edge-history flops. SS_n resets to the "selected"
  // level so a select held low across reset never looks like a new frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_sync_q   <= '0;
      ss_prev_q   <= 1'b0;
      sclk_sync_q <= '1;
      sclk_prev_q <= 1'b1;
      mosi_sync_q <= '0;
    end else begin
      ss_sync_q   <= {ss_sync_q[0], SS_n};
      ss_prev_q   <= ss_sync_q[1];
      sclk_sync_q <= {sclk_sync_q[0], SCLK};
      sclk_prev_q <= sclk_sync_q[1];
      mosi_sync_q <= {mosi_sync_q[0], MOSI};
    end
  end

  assign ss_s      = ss_sync_q[1];
  assign sclk_s    = sclk_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign ss_fall   = ss_prev_q & ~ss_s;
  assign ss_rise   = ~ss_prev_q & ss_s;
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign rise_ok   = sclk_rise & ~ss_s & ((state_q == CMD) || (state_q == DATA));

  // Frame FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (ss_fall) state_d = CMD;
      CMD: begin
        if (ss_rise) state_d = IDLE;
        else if (rise_ok && bit_cnt_q == 5'd7) state_d = DATA;
      end
      DATA: begin
        if (ss_rise) state_d = IDLE;
        else if (rise_ok && bit_cnt_q == 5'd15) state_d = DONE;
      end
      DONE: if (ss_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read mux; address is the 7 bits completed by the 8th rise.
  assign rd_addr = {rx_q[5:0], mosi_s};
  always_comb begin
    rd_byte = '0;
    case (rd_addr)
      7'h0D:   rd_byte = int_cfg_q;
      7'h0F:   rd_byte = WHO_AM_I;
      7'h10:   rd_byte = accl_cfg_q;
      7'h11:   rd_byte = gyro_cfg_q;
      7'h14:   rd_byte = rnd_cfg_q;
      7'h22:   rd_byte = snap_ptch_q[7:0];
      7'h23:   rd_byte = snap_ptch_q[15:8];
      7'h24:   rd_byte = snap_roll_q[7:0];
      7'h25:   rd_byte = snap_roll_q[15:8];
      7'h26:   rd_byte = snap_yaw_q[7:0];
      7'h27:   rd_byte = snap_yaw_q[15:8];
      7'h28:   rd_byte = snap_ax_q[7:0];
      7'h29:   rd_byte = snap_ax_q[15:8];
      7'h2A:   rd_byte = snap_ay_q[7:0];
      7'h2B:   rd_byte = snap_ay_q[15:8];
      default: rd_byte = '0;
    endcase
  end

  // Shift datapath: capture on SCLK rise, drive MISO on SCLK fall.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    wr_go_d   = 1'b0;
    if (ss_fall) begin
      bit_cnt_d = '0;
      rx_d      = '0;
      miso_d    = 1'b0;
    end else if (rise_ok) begin
      bit_cnt_d = bit_cnt_q + 5'd1;
      rx_d      = {rx_q[14:0], mosi_s};
      if (bit_cnt_q == 5'd7)  tx_d = rx_q[6] ? rd_byte : 8'h00;
      if (bit_cnt_q == 5'd15) wr_go_d = 1'b1;
    end else if (sclk_fall && !ss_s && bit_cnt_q >= 5'd8 && bit_cnt_q < 5'd16) begin
      miso_d = tx_q[7];
      tx_d   = {tx_q[6:0], 1'b0};
    end
    if (ss_s) miso_d = 1'b1;
  end

  // Register writes land one clk after the 16th rise, from the full frame in rx_q.
  always_comb begin
    int_cfg_d  = int_cfg_q;
    accl_cfg_d = accl_cfg_q;
    gyro_cfg_d = gyro_cfg_q;
    rnd_cfg_d  = rnd_cfg_q;
    if (wr_go_q && !rx_q[15]) begin
      case (rx_q[14:8])
        7'h0D:   int_cfg_d  = rx_q[7:0];
        7'h10:   accl_cfg_d = rx_q[7:0];
        7'h11:   gyro_cfg_d = rx_q[7:0];
        7'h14:   rnd_cfg_d  = rx_q[7:0];
        default: ;
      endcase
    end
  end

  // Snapshot loading: immediate when deselected, else held until SS_n rises.
  always_comb begin
    snap_ptch_d = snap_ptch_q;
    snap_roll_d = snap_roll_q;
    snap_yaw_d  = snap_yaw_q;
    snap_ax_d   = snap_ax_q;
    snap_ay_d   = snap_ay_q;
    hold_ptch_d = hold_ptch_q;
    hold_roll_d = hold_roll_q;
    hold_yaw_d  = hold_yaw_q;
    hold_ax_d   = hold_ax_q;
    hold_ay_d   = hold_ay_q;
    pending_d   = pending_q;
    load_d      = 1'b0;
    if (smpl_vld && ss_s) begin
      snap_ptch_d = ptch_rt;
      snap_roll_d = roll_rt;
      snap_yaw_d  = yaw_rt;
      snap_ax_d   = ax;
      snap_ay_d   = ay;
      pending_d   = 1'b0;
      load_d      = 1'b1;
    end else if (smpl_vld) begin
      hold_ptch_d = ptch_rt;
      hold_roll_d = roll_rt;
      hold_yaw_d  = yaw_rt;
      hold_ax_d   = ax;
      hold_ay_d   = ay;
      pending_d   = 1'b1;
    end else if (pending_q && ss_s) begin
      snap_ptch_d = hold_ptch_q;
      snap_roll_d = hold_roll_q;
      snap_yaw_d  = hold_yaw_q;
      snap_ax_d   = hold_ax_q;
      snap_ay_d   = hold_ay_q;
      pending_d   = 1'b0;
      load_d      = 1'b1;
    end
  end

  // INT: set after a load (wins over a same-cycle clear), cleared by a
  // completed 0x2B read or by writing int_cfg[1]=0.
  assign int_clr = (state_q == DONE && ss_rise && rx_q[15] && rx_q[14:8] == 7'h2B) ||
                   (wr_go_q && !rx_q[15] && rx_q[14:8] == 7'h0D && !rx_q[1]);
  always_comb begin
    int_d = int_q;
    if (int_clr) int_d = 1'b0;
    if (load_q && int_cfg_q[1]) int_d = 1'b1;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      miso_q      <= 1'b1;
      wr_go_q     <= 1'b0;
      int_cfg_q   <= '0;
      accl_cfg_q  <= '0;
      gyro_cfg_q  <= '0;
      rnd_cfg_q   <= '0;
      snap_ptch_q <= '0;
      snap_roll_q <= '0;
      snap_yaw_q  <= '0;
      snap_ax_q   <= '0;
      snap_ay_q   <= '0;
      hold_ptch_q <= '0;
      hold_roll_q <= '0;
      hold_yaw_q  <= '0;
      hold_ax_q   <= '0;
      hold_ay_q   <= '0;
      pending_q   <= 1'b0;
      load_q      <= 1'b0;
      int_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      wr_go_q     <= wr_go_d;
      int_cfg_q   <= int_cfg_d;
      accl_cfg_q  <= accl_cfg_d;
      gyro_cfg_q  <= gyro_cfg_d;
      rnd_cfg_q   <= rnd_cfg_d;
      snap_ptch_q <= snap_ptch_d;
      snap_roll_q <= snap_roll_d;
      snap_yaw_q  <= snap_yaw_d;
      snap_ax_q   <= snap_ax_d;
      snap_ay_q   <= snap_ay_d;
      hold_ptch_q <= hold_ptch_d;
      hold_roll_q <= hold_roll_d;
      hold_yaw_q  <= hold_yaw_d;
      hold_ax_q   <= hold_ax_d;
      hold_ay_q   <= hold_ay_d;
      pending_q   <= pending_d;
      load_q      <= load_d;
      int_q       <= int_d;
    end
  end

  assign MISO     = miso_q;
  assign INT      = int_q;
  assign int_cfg  = int_cfg_q;
  assign accl_cfg = accl_cfg_q;
  assign gyro_cfg = gyro_cfg_q;
  assign rnd_cfg  = rnd_cfg_q;

endmodule

// File: tb/tb_inert_spi_resp.sv
// Directed bench for inert_spi_resp: bit-banged SPI mode-3 master.
module tb_inert_spi_resp;

  logic        clk = 1'b0;
  logic        rst, SS_n, SCLK, MOSI, smpl_vld;
  logic        MISO, INT;
  logic [15:0] ptch_rt, roll_rt, yaw_rt, ax, ay;
  logic [7:0]  int_cfg, accl_cfg, gyro_cfg, rnd_cfg;

  int n_tests = 0;
  int n_fail  = 0;

  inert_spi_resp #(.WHO_AM_I(8'h6A)) dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .INT(INT),
    .ptch_rt(ptch_rt), .roll_rt(roll_rt), .yaw_rt(yaw_rt), .ax(ax), .ay(ay),
    .smpl_vld(smpl_vld),
    .int_cfg(int_cfg), .accl_cfg(accl_cfg), .gyro_cfg(gyro_cfg), .rnd_cfg(rnd_cfg)
  );

  always #5 clk = ~clk;

  // One SPI frame, SCLK half period = 8 clk. Sends n_bits MSBs of frame;
  // pulses smpl_vld during bit pulse_bit (-1 for none). Returns MISO bits
  // sampled just before each rise and INT just before SS_n rises.
  task automatic spi_xfer(input logic [15:0] frame, input int n_bits, input int pulse_bit,
                          output logic [15:0] resp, output logic int_at_end);
    resp = '0;
    SS_n = 1'b0;
    #80;
    for (int i = 15; i >= 16 - n_bits; i--) begin
      SCLK = 1'b0;
      MOSI = frame[i];
      if (i == pulse_bit) begin
        #10 smpl_vld = 1'b1;
        #10 smpl_vld = 1'b0;
        #60;
      end else begin
        #80;
      end
      resp[i] = MISO;
      SCLK = 1'b1;
      #80;
    end
    int_at_end = INT;
    SS_n = 1'b1;
    MOSI = 1'b1;
    #80;
  endtask

  task automatic pulse_smpl();
    smpl_vld = 1'b1;
    #10 smpl_vld = 1'b0;
    #40;
  endtask

  task automatic test_reset();
    #23;
    n_tests++; if (MISO !== 1'b1) begin $display("FAIL reset_miso: got %b expected 1", MISO); n_fail++; end
    n_tests++; if (INT !== 1'b0) begin $display("FAIL reset_int: got %b expected 0", INT); n_fail++; end
    n_tests++; if (int_cfg !== 8'h00) begin $display("FAIL reset_int_cfg: got %h expected 00", int_cfg); n_fail++; end
    n_tests++; if (accl_cfg !== 8'h00) begin $display("FAIL reset_accl_cfg: got %h expected 00", accl_cfg); n_fail++; end
    n_tests++; if (gyro_cfg !== 8'h00) begin $display("FAIL reset_gyro_cfg: got %h expected 00", gyro_cfg); n_fail++; end
    n_tests++; if (rnd_cfg !== 8'h00) begin $display("FAIL reset_rnd_cfg: got %h expected 00", rnd_cfg); n_fail++; end
    @(negedge clk);
    rst = 1'b0;
    #40;
  endtask

  task automatic test_write_cfg();
    logic [15:0] r;
    logic ie;
    spi_xfer(16'h0D02, 16, -1, r, ie);
    spi_xfer(16'h1062, 16, -1, r, ie);
    spi_xfer(16'h1162, 16, -1, r, ie);
    spi_xfer(16'h1460, 16, -1, r, ie);
    n_tests++; if (int_cfg !== 8'h02) begin $display("FAIL wr_int_cfg: got %h expected 02", int_cfg); n_fail++; end
    n_tests++; if (accl_cfg !== 8'h62) begin $display("FAIL wr_accl_cfg: got %h expected 62", accl_cfg); n_fail++; end
    n_tests++; if (gyro_cfg !== 8'h62) begin $display("FAIL wr_gyro_cfg: got %h expected 62", gyro_cfg); n_fail++; end
    n_tests++; if (rnd_cfg !== 8'h60) begin $display("FAIL wr_rnd_cfg: got %h expected 60", rnd_cfg); n_fail++; end
    spi_xfer(16'h9000, 16, -1, r, ie);
    n_tests++; if (r !== 16'h0062) begin $display("FAIL rd_accl_cfg: got %h expected 0062", r); n_fail++; end
  endtask

  task automatic test_sample_read();
    logic [15:0] r;
    logic ie;
    n_tests++; if (INT !== 1'b0) begin $display("FAIL int_before_sample: got %b expected 0", INT); n_fail++; end
    ptch_rt = 16'h1234;
    pulse_smpl();
    n_tests++; if (INT !== 1'b1) begin $display("FAIL int_after_sample: got %b expected 1", INT); n_fail++; end
    ptch_rt = 16'hFFFF;
    spi_xfer(16'hA200, 16, -1, r, ie);
    n_tests++; if (r !== 16'h0034) begin $display("FAIL rd_ptch_l: got %h expected 0034", r); n_fail++; end
    spi_xfer(16'hA300, 16, -1, r, ie);
    n_tests++; if (r !== 16'h0012) begin $display("FAIL rd_ptch_h: got %h expected 0012", r); n_fail++; end
    n_tests++; if (MISO !== 1'b1) begin $display("FAIL miso_idle: got %b expected 1", MISO); n_fail++; end
  endtask

  task automatic test_full_read();
    logic [15:0] r;
    logic ie;
    logic [7:0] exp_b [10];
    logic [7:0] addr;
    exp_b = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE, 8'hEF, 8'hBE};
    ptch_rt = 16'h1234; roll_rt = 16'h5678; yaw_rt = 16'h9ABC; ax = 16'hDEF0; ay = 16'hBEEF;
    pulse_smpl();
    for (int k = 0; k < 10; k++) begin
      addr = 8'hA2 + 8'(k);
      spi_xfer({addr, 8'h00}, 16, -1, r, ie);
      n_tests++;
      if (r !== {8'h00, exp_b[k]}) begin
        $display("FAIL rd_seq_%h: got %h expected %h", addr, r, {8'h00, exp_b[k]}); n_fail++;
      end
      if (k == 8) begin
        n_tests++; if (INT !== 1'b1) begin $display("FAIL int_before_2b: got %b expected 1", INT); n_fail++; end
      end
      if (k == 9) begin
        n_tests++; if (ie !== 1'b1) begin $display("FAIL int_during_2b: got %b expected 1", ie); n_fail++; end
        n_tests++; if (INT !== 1'b0) begin $display("FAIL int_after_2b: got %b expected 0", INT); n_fail++; end
      end
    end
  endtask

  task automatic test_pending();
    logic [15:0] r;
    logic ie;
    roll_rt = 16'hA5C3;
    spi_xfer(16'hA400, 16, 10, r, ie);
    n_tests++; if (r !== 16'h0078) begin $display("FAIL pend_old_roll: got %h expected 0078", r); n_fail++; end
    n_tests++; if (ie !== 1'b0) begin $display("FAIL pend_int_in_frame: got %b expected 0", ie); n_fail++; end
    n_tests++; if (INT !== 1'b1) begin $display("FAIL pend_int_after: got %b expected 1", INT); n_fail++; end
    roll_rt = 16'h0000;
    spi_xfer(16'hA400, 16, -1, r, ie);
    n_tests++; if (r !== 16'h00C3) begin $display("FAIL pend_new_roll_l: got %h expected 00c3", r); n_fail++; end
    spi_xfer(16'hA500, 16, -1, r, ie);
    n_tests++; if (r !== 16'h00A5) begin $display("FAIL pend_new_roll_h: got %h expected 00a5", r); n_fail++; end
  endtask

  task automatic test_abort();
    logic [15:0] r;
    logic ie;
    spi_xfer(16'h1462, 10, -1, r, ie);
    n_tests++; if (rnd_cfg !== 8'h60) begin $display("FAIL abort_rnd_cfg: got %h expected 60", rnd_cfg); n_fail++; end
    n_tests++; if (MISO !== 1'b1) begin $display("FAIL abort_miso: got %b expected 1", MISO); n_fail++; end
    spi_xfer(16'h1462, 16, -1, r, ie);
    n_tests++; if (rnd_cfg !== 8'h62) begin $display("FAIL after_abort_rnd_cfg: got %h expected 62", rnd_cfg); n_fail++; end
  endtask

  task automatic test_misc_addr();
    logic [15:0] r;
    logic ie;
    spi_xfer(16'h8F00, 16, -1, r, ie);
    n_tests++; if (r !== 16'h006A) begin $display("FAIL who_am_i: got %h expected 006a", r); n_fail++; end
    spi_xfer(16'hB000, 16, -1, r, ie);
    n_tests++; if (r !== 16'h0000) begin $display("FAIL rd_unmapped: got %h expected 0000", r); n_fail++; end
    spi_xfer(16'h2255, 16, -1, r, ie);
    n_tests++;
    if ({int_cfg, accl_cfg, gyro_cfg, rnd_cfg} !== 32'h02626262) begin
      $display("FAIL wr_unmapped: got %h expected 02626262", {int_cfg, accl_cfg, gyro_cfg, rnd_cfg}); n_fail++;
    end
    spi_xfer(16'hA200, 16, -1, r, ie);
    n_tests++; if (r !== 16'h0034) begin $display("FAIL wr_ro_snapshot: got %h expected 0034", r); n_fail++; end
  endtask

  task automatic test_int_cfg_clear();
    logic [15:0] r;
    logic ie;
    n_tests++; if (INT !== 1'b1) begin $display("FAIL int_pre_clear: got %b expected 1", INT); n_fail++; end
    spi_xfer(16'h0D00, 16, -1, r, ie);
    n_tests++; if (INT !== 1'b0) begin $display("FAIL int_cfg_clear: got %b expected 0", INT); n_fail++; end
    n_tests++; if (int_cfg !== 8'h00) begin $display("FAIL int_cfg_zero: got %h expected 00", int_cfg); n_fail++; end
    pulse_smpl();
    n_tests++; if (INT !== 1'b0) begin $display("FAIL int_masked: got %b expected 0", INT); n_fail++; end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] frame;
    logic [15:0] r;
    logic ie;
    frame = 16'h1062;
    SS_n = 1'b0;
    #80;
    for (int i = 15; i >= 10; i--) begin
      SCLK = 1'b0; MOSI = frame[i]; #80;
      SCLK = 1'b1; #80;
    end
    rst = 1'b1;
    #20;
    n_tests++; if (MISO !== 1'b1) begin $display("FAIL midrst_miso: got %b expected 1", MISO); n_fail++; end
    n_tests++; if (gyro_cfg !== 8'h00) begin $display("FAIL midrst_gyro_cfg: got %h expected 00", gyro_cfg); n_fail++; end
    rst = 1'b0;
    #20;
    for (int i = 9; i >= 0; i--) begin
      SCLK = 1'b0; MOSI = frame[i]; #80;
      SCLK = 1'b1; #80;
    end
    SS_n = 1'b1;
    #80;
    n_tests++; if (accl_cfg !== 8'h00) begin $display("FAIL midrst_discard: got %h expected 00", accl_cfg); n_fail++; end
    spi_xfer(16'h1062, 16, -1, r, ie);
    n_tests++; if (accl_cfg !== 8'h62) begin $display("FAIL post_rst_write: got %h expected 62", accl_cfg); n_fail++; end
    spi_xfer(16'hA300, 16, -1, r, ie);
    n_tests++; if (r !== 16'h0000) begin $display("FAIL post_rst_snapshot: got %h expected 0000", r); n_fail++; end
  endtask

  initial begin
    rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b1; smpl_vld = 1'b0;
    ptch_rt = '0; roll_rt = '0; yaw_rt = '0; ax = '0; ay = '0;
    test_reset();
    test_write_cfg();
    test_sample_read();
    test_full_read();
    test_pending();
    test_abort();
    test_misc_addr();
    test_int_cfg_clear();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
